pbsbf4_decim: RTL and testbench
===============================

// Module: pbsbf4_decim
// PURPOSE
//  4-tap cubic B-spline (binomial 1,3,3,1) anti-alias decimator. It is the
//  return-path counterpart of the 2x spline interpolator on the motor command
//  path: it takes high-rate feedback samples (encoder speed / current) and
//  produces a smoothed stream at 1/DECIM of the input rate for the controller.
//  Unsigned data, sample-qualified by valid strobes. No backpressure.
// PARAMETERS
//  DIN_W    8  input sample width, unsigned; range 2..24
//  DECIM    2  decimation factor; power of two, 2..16
//  PHASE_W  $clog2(DECIM)  phase counter width; derived, do not override
// PORTS
//  clk        in   1        clock
//  n_rst      in   1        synchronous reset, active-low
//  clr        in   1        synchronous stream restart: empties the window, zeroes phase
//  din        in   DIN_W    input sample; sampled only when din_valid=1
//  din_valid  in   1        input sample strobe; may be high every cycle
//  dout       out  DIN_W    decimated, rounded sample
//  dout_valid out  1        one-cycle pulse, dout is new
//  primed     out  1        high once the window holds 4 valid samples
// BEHAVIOUR
//  - Reset (n_rst=0 at posedge): window[0..3]=0, fill=0, phase=0, fire=0,
//    dout=0, dout_valid=0, primed=0. Reset overrides clr and din_valid.
//  - Accept: din_valid=1 at posedge -> window shifts: w0<=w1, w1<=w2, w2<=w3,
//    w3<=din (w0 = oldest). phase<=phase+1 mod DECIM. fill saturates at 3->4.
//    fill is 3 bits, holds 0..4, primed = (fill==4).
//  - Fire condition (registered into 1-bit fire at the same edge):
//    accepted sample AND phase==DECIM-1 (pre-increment) AND fill>=3
//    (pre-increment, i.e. window full after the shift). Otherwise fire<=0.
//  - Arithmetic (cycle after accept, from the updated window):
//    sum = w0 + 3*w1 + 3*w2 + w3, width DIN_W+3.
//    rnd = (sum + 4) >> 3, computed at DIN_W+4 bits. Max is exactly 2^DIN_W-1,
//    so no saturation logic is needed. 3*x is implemented as (x<<1)+x.
//  - Output register: when fire=1 at posedge -> dout<=rnd, dout_valid<=1.
//    Otherwise dout_valid<=0 and dout holds its last value.
//  - Latency: sample accepted at edge E that meets the fire condition ->
//    dout_valid high in the cycle after edge E+1 (2 clocks). Throughput is
//    1 output per DECIM accepted samples, regardless of din_valid gaps.
//  - Idle: din_valid=0 -> window, phase, fill frozen. A pending fire still
//    completes.
//  - clr=1 (n_rst=1): window=0, fill=0, phase=0, fire=0. dout is not changed.
//    An output already in flight in the dout stage still emits its pulse.
//    clr and din_valid in the same cycle: clr wins and the sample is dropped.
//  - Phase alignment: the first output is produced at accepted sample index
//    k = smallest k>=3 with k mod DECIM == DECIM-1 (index counted from reset/clr).
//  - Continuous din_valid=1: dout_valid pulses exactly every DECIM cycles.
// STRUCTURE
//  - pbsbf4_pkg holds the tap constants (1,3,3,1), the norm shift (3), the
//    round constant (4) and a width function ACC_W(din_w)=din_w+4.
//  - One sub-module, pbsbf4_tap_window: a 4-deep shift register plus fill
//    counter and primed output, with clr and accept inputs. Phase/fire control,
//    MAC and the output register live in the top. No multipliers are inferred.
// TESTING (DIN_W=8, DECIM=2 unless noted)
//  1 Reset: n_rst low 3 cycles with din_valid=1, din=8'hFF -> dout=0,
//    dout_valid=0, primed=0. First accepted sample after release is index 0.
//  2 DC: din=100 continuous -> first dout_valid at index 3, then every
//    2 cycles, dout=100. din=255 -> dout=255 (no overflow).
//  3 Impulse: samples 0,0,0,0,80,0,0,0,0,0 -> outputs at idx 3,5,7,9 =
//    0,30,10,0. Each pulse 2 clocks after its firing sample's accept edge.
//  4 Gapped valid: repeat test 3 with din_valid random 30% duty -> identical
//    dout sequence. dout_valid count equals the number of fire conditions.
//  5 clr mid-stream: clr together with din_valid at index 6 -> sample dropped,
//    primed=0, next outputs only after 4 new samples. An in-flight pulse still
//    appears.
//  6 DECIM=4, ramp 0,1,2,... -> outputs at idx 3,7,11 = (0+3+6+3+4)>>3=2, 6, 10.

Source files
------------

// File: rtl/pbsbf4_pkg.sv
// Purpose : shared constants for the (1,3,3,1) B-spline decimator.
// Latency : n/a (package only).
// Backpressure: n/a.
package pbsbf4_pkg;

  // Binomial kernel taps; the 3s are built as (x<<1)+x, so no multipliers.
  localparam int TAP0 = 1;
  localparam int TAP1 = 3;
  localparam int TAP2 = 3;
  localparam int TAP3 = 1;

  // Tap sum is 8, so normalise by >>3 with round-half-up.
  localparam int NORM_SHIFT = 3;
  localparam int RND_C      = 4;

  localparam int WIN_N  = 4;  // window depth
  localparam int FILL_W = 3;  // fill counter holds 0..WIN_N

  // Accumulator width: DIN_W+3 for the sum, +1 headroom for the round add.
  function automatic int ACC_W(input int din_w);
    return din_w + 4;
  endfunction

endpackage

// File: rtl/pbsbf4_tap_window.sv
// Purpose : 4-deep sample window (w0 oldest) with saturating fill count.
// Latency : window updates at the accepting edge.
// Backpressure: none; every accept_i is taken, clr_i wins over accept_i.
// Ports   : clk, n_rst (sync, active-low), clr_i, accept_i, din_i,
//           win_o[3:0] (win_o[0] = oldest), fill_o (0..4), primed_o.
module pbsbf4_tap_window
  import pbsbf4_pkg::*;
#(
  parameter int DIN_W = 8
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         clr_i,
  input  logic                         accept_i,
  input  logic [DIN_W-1:0]             din_i,
  output logic [WIN_N-1:0][DIN_W-1:0]  win_o,
  output logic [FILL_W-1:0]            fill_o,
  output logic                         primed_o
);

  logic [WIN_N-1:0][DIN_W-1:0] win_q, win_d;
  logic [FILL_W-1:0]           fill_q, fill_d;

  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    if (clr_i) begin
      win_d  = '0;
      fill_d = '0;
    end else if (accept_i) begin
      // Newest sample enters at the top, oldest falls out of slot 0.
      win_d = {din_i, win_q[3], win_q[2], win_q[1]};
      if (fill_q != FILL_W'(WIN_N)) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
    end
  end

  assign win_o    = win_q;
  assign fill_o   = fill_q;
  assign primed_o = (fill_q == FILL_W'(WIN_N));

endmodule

// File: rtl/pbsbf4_decim.sv
// Purpose : cubic B-spline (1,3,3,1) anti-alias decimator, output 1 per DECIM accepts.
// Latency : 2 clocks from the firing sample's accept edge to dout_valid.
// Backpressure: none; din_valid may be high every cycle, gaps just stall the window.
// Ports   : clk, n_rst (sync, active-low), clr, din/din_valid in,
//           dout/dout_valid out (one-cycle pulse), primed (window full).
module pbsbf4_decim
  import pbsbf4_pkg::*;
#(
  parameter int DIN_W   = 8,
  parameter int DECIM   = 2,
  parameter int PHASE_W = $clog2(DECIM)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic [DIN_W-1:0] din,
  input  logic             din_valid,
  output logic [DIN_W-1:0] dout,
  output logic             dout_valid,
  output logic             primed
);

  localparam int AW = ACC_W(DIN_W);

  logic                        accept;
  logic [WIN_N-1:0][DIN_W-1:0] win;
  logic [FILL_W-1:0]           fill;

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               fire_q, fire_d;
  logic [DIN_W-1:0]   dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;

  logic [AW-1:0]      w0_e, w1_e, w2_e, w3_e, acc;
  logic [DIN_W-1:0]   rnd;

  // A sample arriving with clr is dropped.
  assign accept = din_valid & ~clr;

  pbsbf4_tap_window #(
    .DIN_W (DIN_W)
  ) u_win (
    .clk      (clk),
    .n_rst    (n_rst),
    .clr_i    (clr),
    .accept_i (accept),
    .din_i    (din),
    .win_o    (win),
    .fill_o   (fill),
    .primed_o (primed)
  );

  // Phase and fire decisions use pre-increment state; fill>=3 means the
  // window is full once this sample has shifted in.
  always_comb begin
    phase_d = phase_q;
    fire_d  = 1'b0;
    if (clr) begin
      phase_d = '0;
    end else if (accept) begin
      phase_d = phase_q + PHASE_W'(1);  // DECIM is a power of two: wraps naturally
      fire_d  = (phase_q == PHASE_W'(DECIM - 1)) && (fill >= FILL_W'(WIN_N - 1));
    end
  end

  // Kernel on the window as it stands the cycle after the firing accept.
  assign w0_e = AW'(win[0]);
  assign w1_e = AW'(win[1]);
  assign w2_e = AW'(win[2]);
  assign w3_e = AW'(win[3]);
  assign acc  = w0_e + (w1_e << 1) + w1_e + (w2_e << 1) + w2_e + w3_e;
  // Full-scale input rounds to exactly 2^DIN_W-1, so truncation is lossless.
  assign rnd  = DIN_W'((acc + AW'(RND_C)) >> NORM_SHIFT);

  // The output stage ignores clr so an in-flight result still emits.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    if (fire_q) begin
      dout_d       = rnd;
      dout_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      phase_q      <= '0;
      fire_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      fire_q       <= fire_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_pbsbf4_decim.sv
// Purpose : directed checks of pbsbf4_decim at DECIM=2 and DECIM=4 (DIN_W=8).
// Latency : n/a.
// Backpressure: n/a.
module tb_pbsbf4_decim;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       clr;
  logic [7:0] din;
  logic       din_valid;

  logic [7:0] dout2, dout4;
  logic       dv2, dv4, primed2, primed4;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  int out2_q[$];
  int t2_q[$];
  int out4_q[$];
  int acc_c[0:15];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pbsbf4_decim #(.DIN_W(8), .DECIM(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .clr(clr), .din(din), .din_valid(din_valid),
    .dout(dout2), .dout_valid(dv2), .primed(primed2)
  );

  pbsbf4_decim #(.DIN_W(8), .DECIM(4)) dut4 (
    .clk(clk), .n_rst(n_rst), .clr(clr), .din(din), .din_valid(din_valid),
    .dout(dout4), .dout_valid(dv4), .primed(primed4)
  );

  // Output collectors, sampled mid-cycle.
  always @(negedge clk) begin
    if (dv2) begin
      out2_q.push_back(int'(dout2));
      t2_q.push_back(cyc);
    end
    if (dv4) out4_q.push_back(int'(dout4));
  end

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d, output int ac);
    din       = d;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    ac        = cyc;
    din_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    idle(3);
    out2_q.delete();
    t2_q.delete();
    out4_q.delete();
  endtask

  // Pops the next DECIM=2 output and checks value and its 2-clock latency.
  task automatic expect_out(input string tag, input int exp_val, input int acc_edge);
    int v, t;
    if (out2_q.size() == 0) begin
      check({tag, "_present"}, 0, 1);
    end else begin
      v = out2_q.pop_front();
      t = t2_q.pop_front();
      check(tag, v, exp_val);
      check({tag, "_lat"}, t - acc_edge, 1);
    end
  endtask

  logic [7:0] imp[0:9] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd80, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  int imp_exp[0:3] = '{0, 30, 10, 0};
  int ac;

  initial begin
    n_rst = 1'b0; clr = 1'b0; din = 8'hFF; din_valid = 1'b1;

    // 1: reset with valid data present
    idle(3);
    check("rst_dout", int'(dout2), 0);
    check("rst_dv", int'(dv2), 0);
    check("rst_primed", int'(primed2), 0);
    check("rst_primed4", int'(primed4), 0);
    n_rst = 1'b1; din_valid = 1'b0;
    idle(2);
    check("rst_idle_nout", out2_q.size(), 0);

    // 2: DC 100 back-to-back, outputs at idx 3,5,7
    for (int i = 0; i < 8; i++) begin
      push(8'd100, ac);
      acc_c[i] = ac;
      if (i == 2) check("dc_not_primed", int'(primed2), 0);
      if (i == 3) check("dc_primed", int'(primed2), 1);
    end
    idle(3);
    check("dc_cnt", out2_q.size(), 3);
    if (t2_q.size() >= 2) check("dc_spacing", t2_q[1] - t2_q[0], 2);
    expect_out("dc_o3", 100, acc_c[3]);
    expect_out("dc_o5", 100, acc_c[5]);
    expect_out("dc_o7", 100, acc_c[7]);

    // DC full scale
    do_clr();
    check("clr_unprimed", int'(primed2), 0);
    for (int i = 0; i < 4; i++) begin
      push(8'd255, ac);
      acc_c[i] = ac;
    end
    idle(3);
    check("fs_cnt", out2_q.size(), 1);
    expect_out("fs_o3", 255, acc_c[3]);

    // 3: impulse, continuous valid
    do_clr();
    for (int i = 0; i < 10; i++) begin
      push(imp[i], ac);
      acc_c[i] = ac;
    end
    idle(3);
    check("imp_cnt", out2_q.size(), 4);
    for (int k = 0; k < 4; k++) expect_out($sformatf("imp_o%0d", 3 + 2 * k), imp_exp[k], acc_c[3 + 2 * k]);

    // 4: impulse with random valid gaps (~30% duty)
    do_clr();
    for (int i = 0; i < 10; i++) begin
      for (int g = 0; g < 8; g++) begin
        if ($urandom_range(0, 9) < 3) break;
        idle(1);
      end
      push(imp[i], ac);
      acc_c[i] = ac;
    end
    idle(4);
    check("gap_cnt", out2_q.size(), 4);
    for (int k = 0; k < 4; k++) expect_out($sformatf("gap_o%0d", 3 + 2 * k), imp_exp[k], acc_c[3 + 2 * k]);

    // 5: clr with a sample at index 6, while idx5's result is in flight
    do_clr();
    for (int i = 0; i < 6; i++) begin
      push(8'((i + 1) * 10), ac);
      acc_c[i] = ac;
    end
    clr = 1'b1; din = 8'd70; din_valid = 1'b1;
    idle(1);
    clr = 1'b0; din_valid = 1'b0;
    check("clr_primed", int'(primed2), 0);
    idle(3);
    check("clr_cnt", out2_q.size(), 2);
    expect_out("clr_o3", 25, acc_c[3]);
    expect_out("clr_o5", 45, acc_c[5]);
    check("clr_dout_hold", int'(dout2), 45);
    for (int i = 0; i < 3; i++) begin
      push(8'((i + 1) * 8), ac);
      acc_c[i] = ac;
    end
    idle(3);
    check("clr_refill_none", out2_q.size(), 0);
    push(8'd32, ac);
    acc_c[3] = ac;
    idle(3);
    check("clr_refill_cnt", out2_q.size(), 1);
    expect_out("clr_refill_o3", 20, acc_c[3]);

    // 6: ramp into both instances; DECIM=4 fires at idx 3,7,11
    do_clr();
    for (int i = 0; i < 12; i++) begin
      push(8'(i), ac);
      acc_c[i] = ac;
    end
    idle(3);
    check("d4_cnt", out4_q.size(), 3);
    if (out4_q.size() == 3) begin
      check("d4_o3", out4_q[0], 2);
      check("d4_o7", out4_q[1], 6);
      check("d4_o11", out4_q[2], 10);
    end
    check("ramp2_cnt", out2_q.size(), 5);
    for (int k = 0; k < 5; k++) expect_out($sformatf("ramp2_o%0d", 3 + 2 * k), 2 + 2 * k, acc_c[3 + 2 * k]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
